prio_encoder_rr: RTL and testbench

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

---
 rtl/prio_pkg.sv | 15 +
 rtl/prio_find_first.sv | 26 ++
 rtl/prio_encoder_rr.sv | 70 +++++++
 tb/tb_prio_encoder_rr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared definitions for the priority / round-robin encoder: mode encodings
// and the index-width helper used to size ports.
package prio_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Index width for n request lines; never below one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational search for the first set request bit at or above start,
// wrapping from N-1 back to 0. Fixed priority uses start = 0.
module prio_find_first
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(start) + k) % N]) begin
        found = 1'b1;
        idx   = W'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Priority encoder with selectable fixed / round-robin arbitration behind a
// single-stage valid/ready output register.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         multi;
  logic         rr;
  logic         accept;
  logic         armed;

  // armed stays low through the first edge after reset release so that edge
  // can never take an accept.
  assign in_ready = armed && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign rr       = (mode_e'(mode) == MODE_RR);
  assign start    = rr ? ptr : '0;
  assign multi    = ((in_req & (in_req - N'(1))) != '0);

  prio_find_first #(.N(N)) u_find (
    .req   (in_req),
    .start (start),
    .idx   (win_idx),
    .found (win_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_none  <= 1'b0;
      out_multi <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        out_valid <= 1'b1;
        out_idx   <= win_idx;
        out_none  <= !win_found;
        out_multi <= multi;
        if (rr && win_found) begin
          ptr <= (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an N=8 instance for most scenarios and
// an N=5 instance for non-power-of-two round-robin wrap.
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, mode, out_valid, out_ready, out_none, out_multi;
  logic [7:0] in_req;
  logic [2:0] out_idx;

  logic       b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_out_none, b_out_multi;
  logic [4:0] b_in_req;
  logic [2:0] b_out_idx;

  int n_cmp = 0;
  int n_err = 0;

  prio_encoder_rr #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_none(out_none), .out_multi(out_multi)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_req(b_in_req), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_none(b_out_none), .out_multi(b_out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_req = '0; mode = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_req = '0; b_mode = 1'b0; b_out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_idx, out_none, out_multi, in_ready} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b idx=%0d none=%b multi=%b rdy=%b, want all 0",
               out_valid, out_idx, out_none, out_multi, in_ready);
    end
    step(); step();
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_req = 8'h01; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL release_ready: got %b want 0", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL no_accept_on_release: got out_valid=%b want 0", out_valid);
    end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_release: got %b want 1", in_ready);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_req = 8'b0010_0100;
    step();
    n_cmp++;
    if ({out_valid, out_idx, out_multi, out_none} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL fixed_24: got v=%b idx=%0d multi=%b none=%b, want v=1 idx=2 multi=1 none=0",
               out_valid, out_idx, out_multi, out_none);
    end
    in_req = 8'h80;
    step();
    n_cmp++;
    if ({out_valid, out_idx, out_multi, out_none} !== {1'b1, 3'd7, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL fixed_80: got v=%b idx=%0d multi=%b none=%b, want v=1 idx=7 multi=0 none=0",
               out_valid, out_idx, out_multi, out_none);
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL pop_clears_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_rr_rotation();
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i % 8)) begin
        n_err++;
        $display("FAIL rr_rotate[%0d]: got v=%b idx=%0d, want v=1 idx=%0d",
                 i, out_valid, out_idx, i % 8);
      end
    end
  endtask

  // Pointer is 1 on entry (last winner was 0).
  task automatic test_rr_wrap();
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    in_req = 8'b0100_0000;
    step();
    n_cmp++;
    if (out_idx !== 3'd6) begin
      n_err++; $display("FAIL wrap_setup: got idx=%0d want 6", out_idx);
    end
    in_req = 8'b0000_0011;
    step();
    n_cmp++;
    if (out_idx !== 3'd0) begin
      n_err++; $display("FAIL wrap_first: got idx=%0d want 0", out_idx);
    end
    step();
    n_cmp++;
    if (out_idx !== 3'd1) begin
      n_err++; $display("FAIL wrap_second: got idx=%0d want 1", out_idx);
    end
  endtask

  // Pointer is 2 on entry.
  task automatic test_zero_and_hold();
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_req = 8'h00;
    step();
    n_cmp++;
    if ({out_valid, out_idx, out_none, out_multi} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL zero_vec: got v=%b idx=%0d none=%b multi=%b, want v=1 idx=0 none=1 multi=0",
               out_valid, out_idx, out_none, out_multi);
    end
    in_req = 8'b0000_0111;
    step();
    n_cmp++;
    if (out_idx !== 3'd2 || out_none !== 1'b0) begin
      n_err++; $display("FAIL ptr_after_zero: got idx=%0d none=%b want idx=2 none=0", out_idx, out_none);
    end
    mode = 1'b0; in_req = 8'b0000_1001;
    step();
    n_cmp++;
    if (out_idx !== 3'd0) begin
      n_err++; $display("FAIL fixed_ignores_ptr: got idx=%0d want 0", out_idx);
    end
    mode = 1'b1;
    step();
    n_cmp++;
    if (out_idx !== 3'd3) begin
      n_err++; $display("FAIL ptr_held_by_fixed: got idx=%0d want 3", out_idx);
    end
  endtask

  // Pointer is 4 on entry.
  task automatic test_backpressure();
    mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_req = 8'h10;
    step();
    n_cmp++;
    if (out_idx !== 3'd4) begin
      n_err++; $display("FAIL bp_load: got idx=%0d want 4", out_idx);
    end
    out_ready = 1'b0; in_req = 8'h02;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 3'd4) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b idx=%0d, want rdy=0 v=1 idx=4",
                 i, in_ready, out_valid, out_idx);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1) begin
      n_err++; $display("FAIL bp_pop_accept: got v=%b idx=%0d, want v=1 idx=1", out_valid, out_idx);
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_req = 8'h28;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_multi !== 1'b1) begin
      n_err++; $display("FAIL ar_setup: got v=%b idx=%0d multi=%b want v=1 idx=3 multi=1",
                        out_valid, out_idx, out_multi);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_idx, out_none, out_multi, in_ready} !== 7'b0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b idx=%0d none=%b multi=%b rdy=%b, want all 0",
               out_valid, out_idx, out_none, out_multi, in_ready);
    end
    #2 rst_n = 1'b1;
    step();
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_req = 8'h21;
    step();
    n_cmp++;
    if (out_idx !== 3'd0) begin
      n_err++; $display("FAIL ptr_reset: got idx=%0d want 0", out_idx);
    end
    in_req = 8'h80;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      n_err++; $display("FAIL ar_rr_80: got v=%b idx=%0d want v=1 idx=7", out_valid, out_idx);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_n5();
    b_mode = 1'b1; b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_req = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_out_idx !== ((i % 2 == 0) ? 3'd0 : 3'd4)) begin
        n_err++;
        $display("FAIL n5_alt[%0d]: got v=%b idx=%0d, want v=1 idx=%0d",
                 i, b_out_valid, b_out_idx, (i % 2 == 0) ? 0 : 4);
      end
    end
    b_in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_rr_wrap();
    test_zero_and_hold();
    test_backpressure();
    test_async_reset();
    test_n5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
